// File: rtl/multi_clock_suite_serial_tx_pkg.sv
// Shared state encoding and sizing helper for the serial transmitter.
package multi_clock_suite_serial_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Beat counter width; a 2-bit word still needs one counter bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

endpackage

// File: rtl/multi_clock_suite_serial_tx_if.sv
// Decoupled word-in / bit-out link of the serial transmitter.
interface multi_clock_suite_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_bits;
  logic             io_out_valid;
  logic             io_out_ready;
  logic             io_out_bits;
  logic             io_out_last;
  logic             io_busy;

  modport master (
    output io_in_valid, io_in_bits, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits, io_out_last, io_busy
  );

  modport slave (
    input  io_in_valid, io_in_bits, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits, io_out_last, io_busy
  );
endinterface

// File: rtl/multi_clock_suite_hold_reg.sv
// One-entry holding register: write sets full, clear strobe empties it.
// A write in the same cycle as a clear wins, so a refill keeps it full.
module multi_clock_suite_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_clr,
  output logic             full,
  output logic [WIDTH-1:0] data
);
  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state for the full flag and stored word.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (wr_en) begin
      full_d = 1'b1;
      data_d = wr_data;
    end else if (rd_clr) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Holding register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= {WIDTH{1'b0}};
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;
endmodule

// File: rtl/multi_clock_suite_serial_tx.sv
// Parallel-to-serial transmitter: words land in a hold buffer, then shift out
// LSB-first one bit per accepted beat, back-to-back without bubbles.
module multi_clock_suite_serial_tx
  import multi_clock_suite_serial_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  multi_clock_suite_serial_tx_if.slave  io
);
  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             hold_full;
  logic             hold_wr;
  logic             hold_clr;
  logic [WIDTH-1:0] hold_data;
  logic             in_fire;
  logic             out_fire;
  logic             at_last;

  multi_clock_suite_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (hold_wr),
    .wr_data (io.io_in_bits),
    .rd_clr  (hold_clr),
    .full    (hold_full),
    .data    (hold_data)
  );

  assign in_fire  = io.io_in_valid & ~hold_full;
  assign at_last  = (cnt_q == LAST_CNT);
  assign out_fire = (state_q == SEND) & io.io_out_ready;

  // FSM next state, shift/count update and hold buffer strobes.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    hold_clr = 1'b0;
    hold_wr  = in_fire;
    case (state_q)
      IDLE: begin
        if (hold_full) begin
          shreg_d  = hold_data;
          cnt_d    = {CW{1'b0}};
          hold_clr = 1'b1;
          state_d  = SEND;
        end else begin
          state_d  = IDLE;
        end
      end
      SEND: begin
        if (out_fire && !at_last) begin
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CW'(1'b1);
        end else if (out_fire && hold_full) begin
          shreg_d  = hold_data;
          cnt_d    = {CW{1'b0}};
          hold_clr = 1'b1;
        end else if (out_fire && in_fire) begin
          // Empty hold on the last beat: bypass the incoming word straight in.
          shreg_d = io.io_in_bits;
          cnt_d   = {CW{1'b0}};
          hold_wr = 1'b0;
        end else if (out_fire) begin
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shifter, beat counter and FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.io_in_ready  = ~hold_full;
  assign io.io_out_valid = (state_q == SEND);
  assign io.io_out_bits  = (state_q == SEND) & shreg_q[0];
  assign io.io_out_last  = (state_q == SEND) & at_last;
  assign io.io_busy      = (state_q == SEND) | hold_full;
endmodule
